// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue stage.
// Unit-select codes, FSM state encoding and width defaults.
package alu_pkg;

    localparam int ALU_W_IN  = 16;
    localparam int ALU_W_OUT = 16;

    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef struct packed {
        logic shift;
        logic cmp;
        logic lgc;
        logic arith;
    } unit_en_t;

endpackage

// File: rtl/alu_unit_dec.sv
// Unit-select decoder: 2-bit select plus go into one-hot unit enables.
// All enables stay low while go is low.
module alu_unit_dec
    import alu_pkg::*;
(
    input  logic       i_go,
    input  logic [1:0] i_sel,
    output unit_en_t   o_en
);

    // Raise exactly one enable for the selected unit when go is set
    always_comb begin
        o_en = '0;
        if (i_go) begin
            unique case (i_sel)
                UNIT_ARITH: o_en.arith = 1'b1;
                UNIT_LOGIC: o_en.lgc   = 1'b1;
                UNIT_CMP:   o_en.cmp   = 1'b1;
                UNIT_SHIFT: o_en.shift = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue stage: accepts a command, pulses one unit enable, captures
// the unit result and holds it until consumed. Option: ALU_ISSUE_FLAG_CHECK_EN.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH_IN_DATA  = ALU_W_IN,
    parameter int WIDTH_OUT_DATA = ALU_W_OUT
) (
    input  logic                      CLK_seq,
    input  logic                      RST_seq,
    input  logic                      Cmd_Valid,
    output logic                      Cmd_Ready,
    input  logic [WIDTH_IN_DATA-1:0]  Cmd_A,
    input  logic [WIDTH_IN_DATA-1:0]  Cmd_B,
    input  logic [3:0]                Cmd_Fun,
    output logic [WIDTH_IN_DATA-1:0]  A_unit,
    output logic [WIDTH_IN_DATA-1:0]  B_unit,
    output logic [1:0]                ALU_FUN_unit,
    output logic                      Arith_Enable,
    output logic                      Logic_Enable,
    output logic                      Cmp_Enable,
    output logic                      Shift_Enable,
    input  logic [WIDTH_OUT_DATA:0]   Unit_OUT,
    input  logic                      Unit_Flag,
    output logic                      Res_Valid,
    input  logic                      Res_Ready,
    output logic [WIDTH_OUT_DATA:0]   Res_Data,
    output logic [3:0]                Res_Fun,
    output logic                      Res_Err
);

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic [WIDTH_IN_DATA-1:0]  r_a;
    logic [WIDTH_IN_DATA-1:0]  r_b;
    logic [1:0]                r_sub;
    logic [3:0]                r_fun;
    logic [WIDTH_OUT_DATA:0]   r_data;
    logic                      w_accept;
    logic                      w_go;
    unit_en_t                  w_en;

    // Ready only in IDLE, and never while reset is asserted
    assign Cmd_Ready = (r_state == ST_IDLE) && !RST_seq;
    assign w_accept  = Cmd_Valid && Cmd_Ready;
    assign w_go      = (r_state == ST_ISSUE);

    // Next-state selection for the issue sequence
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  w_state_nxt = ST_RESP;
            ST_RESP:  if (Res_Ready) w_state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset drops any in-flight command
    always_ff @(posedge CLK_seq or posedge RST_seq) begin
        if (RST_seq) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Operand and function capture on accept; held until next accept
    always_ff @(posedge CLK_seq or posedge RST_seq) begin
        if (RST_seq) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sub <= '0;
            r_fun <= '0;
        end else if (w_accept) begin
            r_a   <= Cmd_A;
            r_b   <= Cmd_B;
            r_sub <= Cmd_Fun[1:0];
            r_fun <= Cmd_Fun;
        end
    end

    // Result capture one cycle after the enable pulse
    always_ff @(posedge CLK_seq or posedge RST_seq) begin
        if (RST_seq)                 r_data <= '0;
        else if (r_state == ST_WAIT) r_data <= Unit_OUT;
    end

`ifdef ALU_ISSUE_FLAG_CHECK_EN
    logic r_err;

    // Missing unit flag marks the captured result as suspect
    always_ff @(posedge CLK_seq or posedge RST_seq) begin
        if (RST_seq)                 r_err <= 1'b0;
        else if (r_state == ST_WAIT) r_err <= !Unit_Flag;
    end

    assign Res_Err = r_err;
`else
    logic w_unused_flag;
    assign w_unused_flag = Unit_Flag;
    assign Res_Err       = 1'b0;
`endif

    alu_unit_dec u_dec (
        .i_go  (w_go),
        .i_sel (r_fun[3:2]),
        .o_en  (w_en)
    );

    assign Arith_Enable = w_en.arith;
    assign Logic_Enable = w_en.lgc;
    assign Cmp_Enable   = w_en.cmp;
    assign Shift_Enable = w_en.shift;

    assign A_unit       = r_a;
    assign B_unit       = r_b;
    assign ALU_FUN_unit = r_sub;
    assign Res_Valid    = (r_state == ST_RESP);
    assign Res_Data     = r_data;
    assign Res_Fun      = r_fun;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized self-checking bench for alu_issue_ctrl.
// Includes a behavioural ALU unit model driving Unit_OUT/Unit_Flag.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic [3:0]  cmd_fun = '0;
    logic [15:0] a_unit;
    logic [15:0] b_unit;
    logic [1:0]  fun_unit;
    logic        en_ar, en_lg, en_cm, en_sh;
    logic [16:0] unit_out = '0;
    logic        unit_flag = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [16:0] res_data;
    logic [3:0]  res_fun;
    logic        res_err;

    int n_vec = 0;
    int n_err = 0;
    bit cur_flag = 1'b1;

`ifdef ALU_ISSUE_FLAG_CHECK_EN
    localparam bit FLAG_EN = 1'b1;
`else
    localparam bit FLAG_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .CLK_seq      (clk),
        .RST_seq      (rst),
        .Cmd_Valid    (cmd_valid),
        .Cmd_Ready    (cmd_ready),
        .Cmd_A        (cmd_a),
        .Cmd_B        (cmd_b),
        .Cmd_Fun      (cmd_fun),
        .A_unit       (a_unit),
        .B_unit       (b_unit),
        .ALU_FUN_unit (fun_unit),
        .Arith_Enable (en_ar),
        .Logic_Enable (en_lg),
        .Cmp_Enable   (en_cm),
        .Shift_Enable (en_sh),
        .Unit_OUT     (unit_out),
        .Unit_Flag    (unit_flag),
        .Res_Valid    (res_valid),
        .Res_Ready    (res_ready),
        .Res_Data     (res_data),
        .Res_Fun      (res_fun),
        .Res_Err      (res_err)
    );

    function automatic logic [16:0] alu_ref(input logic [15:0] a,
                                            input logic [15:0] b,
                                            input logic [3:0]  f);
        logic [16:0] ea, eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        case (f)
            4'h0: return ea + eb;
            4'h1: return ea - eb;
            4'h2: return ea + 17'd1;
            4'h3: return ea - 17'd1;
            4'h4: return ea & eb;
            4'h5: return ea | eb;
            4'h6: return ea ^ eb;
            4'h7: return {1'b0, ~a};
            4'h8: return 17'd0;
            4'h9: return (a == b) ? 17'd1 : 17'd0;
            4'hA: return (a > b) ? 17'd2 : 17'd0;
            4'hB: return (a < b) ? 17'd3 : 17'd0;
            4'hC: return ea << 1;
            4'hD: return ea >> 1;
            4'hE: return {1'b0, a << b[3:0]};
            default: return {1'b0, a >> b[3:0]};
        endcase
    endfunction

    // Unit model: registers a result only in a cycle its enable is high
    always @(posedge clk) begin
        logic [1:0] sel;
        sel = en_sh ? 2'd3 : en_cm ? 2'd2 : en_lg ? 2'd1 : 2'd0;
        if (en_ar | en_lg | en_cm | en_sh) begin
            unit_out  <= alu_ref(a_unit, b_unit, {sel, fun_unit});
            unit_flag <= cur_flag;
        end else begin
            unit_out  <= '0;
            unit_flag <= 1'b0;
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ens();
        return {en_sh, en_cm, en_lg, en_ar};
    endfunction

    // Issue one command from an IDLE negedge and follow it to completion
    task automatic run_cmd(input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] f, input int hold,
                           input bit flag);
        logic [16:0] exp_d;
        logic [3:0]  exp_en;
        exp_d  = alu_ref(a, b, f);
        exp_en = 4'b0001 << f[3:2];
        check("rdy_idle", cmd_ready, 1);
        cur_flag  = flag;
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_fun   = f;
        @(posedge clk);
        @(negedge clk);
        cmd_a     = 16'($urandom);
        cmd_b     = 16'($urandom);
        cmd_fun   = 4'($urandom);
        res_ready = 1'($urandom);
        check("en_pulse", ens(), exp_en);
        check("a_unit", a_unit, a);
        check("b_unit", b_unit, b);
        check("fun_unit", fun_unit, f[1:0]);
        check("rdy_busy", cmd_ready, 0);
        check("val_early", res_valid, 0);
        @(negedge clk);
        res_ready = 1'b0;
        check("en_clear", ens(), 0);
        check("val_early2", res_valid, 0);
        check("a_hold", a_unit, a);
        @(negedge clk);
        for (int i = 0; i <= hold; i++) begin
            check("res_valid", res_valid, 1);
            check("res_data", res_data, exp_d);
            check("res_fun", res_fun, f);
            check("res_err", res_err, FLAG_EN ? !flag : 1'b0);
            check("rdy_resp", cmd_ready, 0);
            check("a_hold2", a_unit, a);
            if (i == hold) res_ready = 1'b1;
            @(negedge clk);
        end
        res_ready = 1'b0;
        cmd_valid = 1'b0;
        check("val_fall", res_valid, 0);
        check("rdy_back", cmd_ready, 1);
    endtask

    initial begin
        cmd_valid = 1'b1;
        cmd_a     = 16'hFFFF;
        repeat (2) @(negedge clk);
        check("rst_rdy", cmd_ready, 0);
        check("rst_val", res_valid, 0);
        check("rst_en", ens(), 0);
        check("rst_a", a_unit, 0);
        check("rst_data", res_data, 0);
        check("rst_fun", res_fun, 0);
        check("rst_err", res_err, 0);
        cmd_valid = 1'b0;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_rdy", cmd_ready, 1);
            check("idle_en", ens(), 0);
        end

        run_cmd(16'd5, 16'd5, 4'b1001, 0, 1'b1);
        run_cmd(16'd9, 16'd3, 4'b1010, 5, 1'b1);
        run_cmd(16'h1234, 16'h0F0F, 4'b0000, 0, 1'b1);
        run_cmd(16'h00FF, 16'h0F0F, 4'b0110, 1, 1'b1);
        run_cmd(16'h8001, 16'd4, 4'b1110, 0, 1'b1);
        run_cmd(16'd7, 16'd7, 4'b1001, 0, 1'b0);

        // Reset landing in ISSUE must kill the command
        check("rdy_pre_rst", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_a     = 16'd3;
        cmd_b     = 16'd3;
        cmd_fun   = 4'b1001;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("mid_en", en_cm, 1);
        rst = 1'b1;
        #1;
        check("mid_en_drop", en_cm, 0);
        check("mid_rdy", cmd_ready, 0);
        repeat (2) @(negedge clk);
        check("mid_val", res_valid, 0);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("post_val", res_valid, 0);
            check("post_rdy", cmd_ready, 1);
        end
        check("post_data", res_data, 0);

        for (int k = 0; k < 30; k++) begin
            run_cmd(16'($urandom), 16'($urandom), 4'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
